// File: rtl/img_col_streamer.sv
// img_col_streamer: reads three image rows from the SRAM banks and streams
// 3-pixel vertical columns {top,mid,bot} to the PE image input, with per-beat
// window/row-end sideband and a 2-entry output FIFO that never drops data.
module img_col_streamer #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_ren,
  output logic [ADDR_W-1:0]    mem_addr_t,
  output logic [ADDR_W-1:0]    mem_addr_m,
  output logic [ADDR_W-1:0]    mem_addr_b,
  input  logic [3*PIX_W-1:0]   mem_rdata,
  output logic [3*PIX_W-1:0]   col_out,
  output logic                 col_valid,
  input  logic                 col_ready,
  output logic                 win_valid,
  output logic                 row_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int DW = 3 * PIX_W;
  localparam int EW = DW + 2;

  localparam logic [CW-1:0]     C_LAST   = CW'(IMG_W - 1);
  localparam logic [CW-1:0]     C_WIN    = CW'(2);
  localparam logic [RW-1:0]     R_LAST   = RW'(IMG_H - 3);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_nx;

  logic [CW-1:0]   c;
  logic [RW-1:0]   r;

  // Output FIFO storage; entry layout is {data, win, last}
  logic [EW-1:0]   fifo_q [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      count;

  // Read issued last cycle; its data is on mem_rdata this cycle
  logic            pend;
  logic            pend_win;
  logic            pend_last;

  logic [EW-1:0]   pend_entry;
  logic [EW-1:0]   head;
  logic            pop;
  logic            store;
  logic            deq;
  logic            ren;
  logic            last_rd;
  logic [1:0]      occ_nx;
  logic [ADDR_W-1:0] base_addr;

  // Datapath control: fall-through head, occupancy bookkeeping and read gating
  always_comb begin
    pend_entry = {mem_rdata, pend_win, pend_last};
    col_valid  = (count != 2'd0) || pend;
    // With an empty FIFO the arriving read data is presented directly, so the
    // first beat appears the cycle the SRAM returns it.
    head       = (count != 2'd0) ? fifo_q[rd_ptr] : pend_entry;
    pop        = col_valid && col_ready;
    store      = pend && !((count == 2'd0) && pop);
    deq        = pop && (count != 2'd0);
    occ_nx     = count + {1'b0, pend} - {1'b0, pop};
    ren        = (state == S_FETCH) && (occ_nx < 2'd2);
    last_rd    = ren && (r == R_LAST) && (c == C_LAST);
    base_addr  = ADDR_W'(r) * ROW_STEP + ADDR_W'(c);
  end

  // Next-state logic and state-derived outputs
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_FETCH;
      end
      S_FETCH: begin
        busy = 1'b1;
        if (last_rd) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (occ_nx == 2'd0) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Bus outputs, forced to zero when not qualified
  always_comb begin
    mem_ren    = ren;
    mem_addr_t = ren ? base_addr : '0;
    mem_addr_m = ren ? base_addr + ROW_STEP : '0;
    mem_addr_b = ren ? base_addr + ROW_STEP + ROW_STEP : '0;
    {col_out, win_valid, row_last} = col_valid ? head : '0;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Column/row read counters: c inner, r outer, cleared on pass start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c <= '0;
      r <= '0;
    end else if ((state == S_IDLE) && start) begin
      c <= '0;
      r <= '0;
    end else if (ren) begin
      if (c == C_LAST) begin
        c <= '0;
        r <= (r == R_LAST) ? '0 : r + 1'b1;
      end else begin
        c <= c + 1'b1;
      end
    end
  end

  // In-flight read tracking with the sideband of the issuing (r,c)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend      <= 1'b0;
      pend_win  <= 1'b0;
      pend_last <= 1'b0;
    end else begin
      pend <= ren;
      if (ren) begin
        pend_win  <= (c >= C_WIN);
        pend_last <= (c == C_LAST);
      end
    end
  end

  // Output FIFO: store arriving data unless it bypasses straight out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) fifo_q[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (store) begin
        fifo_q[wr_ptr] <= pend_entry;
        wr_ptr         <= ~wr_ptr;
      end
      if (deq) rd_ptr <= ~rd_ptr;
      count <= occ_nx;
    end
  end

endmodule

// File: tb/tb_img_col_streamer.sv
// tb_img_col_streamer: directed scenarios for img_col_streamer on a 4x4 image
// whose SRAM returns pixel = address[7:0].
module tb_img_col_streamer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        mem_ren;
  logic [9:0]  mem_addr_t;
  logic [9:0]  mem_addr_m;
  logic [9:0]  mem_addr_b;
  logic [23:0] mem_rdata;
  logic [23:0] col_out;
  logic        col_valid;
  logic        col_ready;
  logic        win_valid;
  logic        row_last;

  img_col_streamer #(
    .IMG_W (4),
    .IMG_H (4),
    .PIX_W (8),
    .ADDR_W(10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mem_ren   (mem_ren),
    .mem_addr_t(mem_addr_t),
    .mem_addr_m(mem_addr_m),
    .mem_addr_b(mem_addr_b),
    .mem_rdata (mem_rdata),
    .col_out   (col_out),
    .col_valid (col_valid),
    .col_ready (col_ready),
    .win_valid (win_valid),
    .row_last  (row_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected 8-beat sequence for a 4x4 image
  logic [23:0] exp_d [8] = '{24'h000408, 24'h010509, 24'h02060A, 24'h03070B,
                             24'h04080C, 24'h05090D, 24'h060A0E, 24'h070B0F};
  logic        exp_w [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic        exp_l [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  int checks = 0;
  int fails  = 0;

  // Per-pass observations
  logic [23:0] got_d [16];
  logic        got_w [16];
  logic        got_l [16];
  int   n_beats, n_done, n_reads, done_cyc, last_beat_cyc, first_valid_cyc;
  int   n_unstable, stall_reads, stall_bad;
  logic timed_out, busy_c0, busy_c1, busy_done;
  logic [9:0] rst_snap;

  // Runs one pass from the posedge+1 phase: mode 0 ready=1, 1 random, 2 stall.
  task automatic do_pass(input int mode, input int stall, input int poke_cyc,
                         input int rst_cyc, input int tail);
    logic [23:0] rd_nx;
    logic        prev_hold;
    logic [25:0] prev_val;
    n_beats = 0; n_done = 0; n_reads = 0; done_cyc = -1; last_beat_cyc = -1;
    first_valid_cyc = -1; n_unstable = 0; stall_reads = 0; stall_bad = 0;
    timed_out = 1'b1; busy_c0 = 1'b0; busy_c1 = 1'b0; busy_done = 1'b1;
    for (int i = 0; i < 16; i++) begin
      got_d[i] = 'x; got_w[i] = 1'bx; got_l[i] = 1'bx;
    end
    rd_nx = '0; prev_hold = 1'b0; prev_val = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      start = (cyc == 0) || (cyc == poke_cyc);
      case (mode)
        1:       col_ready = 1'($urandom_range(0, 1));
        2:       col_ready = (cyc >= stall);
        default: col_ready = 1'b1;
      endcase
      mem_rdata = rd_nx;
      if (cyc == rst_cyc) begin
        rst = 1'b1;
        #1;
        rst_snap = {busy, done, mem_ren, col_valid, win_valid, row_last,
                    |mem_addr_t, |mem_addr_m, |mem_addr_b, |col_out};
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; col_ready = 1'b1; timed_out = 1'b0;
        return;
      end
      @(negedge clk);
      if (cyc == 0) busy_c0 = busy;
      if (cyc == 1) busy_c1 = busy;
      if (col_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_hold && (col_valid !== 1'b1 || {col_out, win_valid, row_last} !== prev_val))
        n_unstable++;
      if (mode == 2 && cyc >= 2 && cyc < stall && (col_valid !== 1'b1 || col_out !== 24'h000408))
        stall_bad++;
      if (col_valid === 1'b1 && col_ready) begin
        if (n_beats < 16) begin
          got_d[n_beats] = col_out; got_w[n_beats] = win_valid; got_l[n_beats] = row_last;
        end
        n_beats++;
        last_beat_cyc = cyc;
      end
      if (mem_ren === 1'b1) begin
        rd_nx = {mem_addr_t[7:0], mem_addr_m[7:0], mem_addr_b[7:0]};
        n_reads++;
        if (cyc < stall) stall_reads++;
      end
      if (done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc  = cyc;
          busy_done = busy;
        end
      end
      prev_hold = (col_valid === 1'b1) && !col_ready;
      prev_val  = {col_out, win_valid, row_last};
      @(posedge clk); #1;
      if (done_cyc >= 0 && cyc >= done_cyc + tail) begin
        start = 1'b0; col_ready = 1'b1; timed_out = 1'b0;
        return;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; col_ready = 1'b1; mem_rdata = '0;
    #2;
    checks++;
    if ({busy, done, mem_ren, col_valid, win_valid, row_last, col_out, mem_addr_t} !== '0) begin
      fails++;
      $display("FAIL reset_initial: got busy=%b done=%b ren=%b valid=%b col=%h addr_t=%h, expected all 0",
               busy, done, mem_ren, col_valid, col_out, mem_addr_t);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_pass(0, 0, -1, 5, 0);
    checks++;
    if (rst_snap !== 10'b0) begin
      fails++;
      $display("FAIL reset_midpass: got output flags %b, expected 0000000000", rst_snap);
    end
    @(posedge clk); #1;
    do_pass(0, 0, -1, -1, 3);
    checks++;
    if (timed_out || n_beats != 8) begin
      fails++;
      $display("FAIL reset_repass_count: got %0d beats (timeout=%b), expected 8", n_beats, timed_out);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({got_d[i], got_w[i], got_l[i]} !== {exp_d[i], exp_w[i], exp_l[i]}) begin
        fails++;
        $display("FAIL reset_repass beat %0d: got %h/%b/%b expected %h/%b/%b",
                 i, got_d[i], got_w[i], got_l[i], exp_d[i], exp_w[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_stream();
    do_pass(0, 0, -1, -1, 3);
    checks++;
    if (timed_out || n_beats != 8 || n_done != 1) begin
      fails++;
      $display("FAIL stream_count: got beats=%0d dones=%0d timeout=%b, expected 8/1/0",
               n_beats, n_done, timed_out);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({got_d[i], got_w[i], got_l[i]} !== {exp_d[i], exp_w[i], exp_l[i]}) begin
        fails++;
        $display("FAIL stream beat %0d: got %h/%b/%b expected %h/%b/%b",
                 i, got_d[i], got_w[i], got_l[i], exp_d[i], exp_w[i], exp_l[i]);
      end
    end
    checks++;
    if (first_valid_cyc != 2) begin
      fails++;
      $display("FAIL stream_latency: first col_valid at cycle %0d, expected 2", first_valid_cyc);
    end
    checks++;
    if (done_cyc != last_beat_cyc + 1 || last_beat_cyc != 9) begin
      fails++;
      $display("FAIL stream_done_timing: done at %0d last beat at %0d, expected 10 and 9",
               done_cyc, last_beat_cyc);
    end
    checks++;
    if ({busy_c0, busy_c1, busy_done} !== 3'b010) begin
      fails++;
      $display("FAIL stream_busy: got busy(c0,c1,done)=%b, expected 010", {busy_c0, busy_c1, busy_done});
    end
  endtask

  task automatic test_backpressure();
    do_pass(1, 0, -1, -1, 3);
    checks++;
    if (timed_out || n_beats != 8 || n_done != 1) begin
      fails++;
      $display("FAIL bp_count: got beats=%0d dones=%0d timeout=%b, expected 8/1/0",
               n_beats, n_done, timed_out);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({got_d[i], got_w[i], got_l[i]} !== {exp_d[i], exp_w[i], exp_l[i]}) begin
        fails++;
        $display("FAIL bp beat %0d: got %h/%b/%b expected %h/%b/%b",
                 i, got_d[i], got_w[i], got_l[i], exp_d[i], exp_w[i], exp_l[i]);
      end
    end
    checks++;
    if (n_unstable != 0) begin
      fails++;
      $display("FAIL bp_stability: got %0d unstable held beats, expected 0", n_unstable);
    end
  endtask

  task automatic test_stall();
    do_pass(2, 10, -1, -1, 3);
    checks++;
    if (stall_reads > 2 || stall_reads < 1) begin
      fails++;
      $display("FAIL stall_reads: got %0d reads during stall, expected 1..2", stall_reads);
    end
    checks++;
    if (stall_bad != 0) begin
      fails++;
      $display("FAIL stall_hold: got %0d cycles without beat 0 held, expected 0", stall_bad);
    end
    checks++;
    if (timed_out || n_beats != 8 || n_unstable != 0) begin
      fails++;
      $display("FAIL stall_resume: got beats=%0d unstable=%0d timeout=%b, expected 8/0/0",
               n_beats, n_unstable, timed_out);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({got_d[i], got_w[i], got_l[i]} !== {exp_d[i], exp_w[i], exp_l[i]}) begin
        fails++;
        $display("FAIL stall beat %0d: got %h/%b/%b expected %h/%b/%b",
                 i, got_d[i], got_w[i], got_l[i], exp_d[i], exp_w[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_start_busy();
    do_pass(0, 0, 5, -1, 4);
    checks++;
    if (timed_out || n_beats != 8 || n_reads != 8) begin
      fails++;
      $display("FAIL busy_start_count: got beats=%0d reads=%0d timeout=%b, expected 8/8/0",
               n_beats, n_reads, timed_out);
    end
    checks++;
    if (n_done != 1) begin
      fails++;
      $display("FAIL busy_start_done: got %0d done pulses, expected 1", n_done);
    end
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_start_idle: got busy=%b after pass, expected 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    do_pass(0, 0, -1, -1, 0);
    checks++;
    if (timed_out || n_beats != 8) begin
      fails++;
      $display("FAIL b2b_first: got beats=%0d timeout=%b, expected 8/0", n_beats, timed_out);
    end
    do_pass(0, 0, -1, -1, 3);
    checks++;
    if (timed_out || n_beats != 8 || n_done != 1 || first_valid_cyc != 2) begin
      fails++;
      $display("FAIL b2b_second: got beats=%0d dones=%0d first_valid=%0d timeout=%b, expected 8/1/2/0",
               n_beats, n_done, first_valid_cyc, timed_out);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({got_d[i], got_w[i], got_l[i]} !== {exp_d[i], exp_w[i], exp_l[i]}) begin
        fails++;
        $display("FAIL b2b beat %0d: got %h/%b/%b expected %h/%b/%b",
                 i, got_d[i], got_w[i], got_l[i], exp_d[i], exp_w[i], exp_l[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_stall();
    test_start_busy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
